adc4proc: RTL and testbench

Per-channel sample processor placed directly downstream of the 4-channel ADC deserializer. Each CLK it takes the 48-bit, 8-lane, 6-bit-per-lane word and rebuilds four 12-bit samples, with optional per-channel inversion. It subtracts a per-channel pedestal to produce signed 13-bit data, and runs a per-channel threshold discriminator with hold-off. A built-in ramp test-pattern checker supports link qualification after bitslip alignment.

---
 rtl/adc4proc.sv | 126 ++++++++++++
 tb/tb_adc4proc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc4proc.sv
// Four-channel ADC sample processor: lane unpack, optional inversion, pedestal subtraction,
// threshold discriminator with hold-off, and a ramp test-pattern checker.
module adc4proc #(
  parameter int unsigned HOLDOFF = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [47:0] DIN,
  input  logic [3:0]  INV,
  input  logic [47:0] PED,
  input  logic [47:0] THR,
  input  logic        CHKEN,
  input  logic        ERRCLR,
  output logic [51:0] DOUT,
  output logic [3:0]  TRIG,
  output logic        TRIGANY,
  output logic [15:0] ERRCNT
);

  typedef enum logic [1:0] {StArmed, StHold, StWaitLow} state_e;

  logic [11:0] s_d      [4];
  logic [11:0] s_q      [4];
  logic [11:0] prev_q   [4];
  logic [12:0] dout_d   [4];
  logic [12:0] dout_q   [4];
  logic [7:0]  cnt_d    [4];
  logic [7:0]  cnt_q    [4];
  state_e      state_d  [4];
  state_e      state_q  [4];
  logic [3:0]  above;
  logic [3:0]  trig_d;
  logic [3:0]  trig_q;
  logic        mismatch;
  logic        primed_q;
  logic [15:0] errcnt_q;

  // Lane 2k carries the MSBs, lane 2k+1 the LSBs of channel k.
  always_comb begin
    logic [11:0] raw;
    raw      = '0;
    mismatch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      raw      = {DIN[12*k +: 6], DIN[12*k+6 +: 6]};
      s_d[k]   = INV[k] ? ~raw : raw;
      mismatch = mismatch | (s_d[k] != prev_q[k] + 12'd1);
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dout_d[k] = {1'b0, s_q[k]} - {1'b0, PED[12*k +: 12]};
      above[k]  = $signed(dout_q[k]) > $signed({1'b0, THR[12*k +: 12]});
    end
  end

  always_comb begin
    trig_d = '0;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        StArmed: begin
          if (above[k]) begin
            trig_d[k]  = 1'b1;
            cnt_d[k]   = 8'(HOLDOFF - 1);
            state_d[k] = StHold;
          end
        end
        StHold: begin
          if (cnt_q[k] == 8'd0) begin
            state_d[k] = above[k] ? StWaitLow : StArmed;
          end else begin
            cnt_d[k] = cnt_q[k] - 8'd1;
          end
        end
        StWaitLow: begin
          if (!above[k]) state_d[k] = StArmed;
        end
        default: state_d[k] = StArmed;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < 4; k++) begin
        s_q[k]     <= '0;
        prev_q[k]  <= '0;
        dout_q[k]  <= '0;
        cnt_q[k]   <= '0;
        state_q[k] <= StArmed;
      end
      trig_q   <= '0;
      primed_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        s_q[k]     <= s_d[k];
        prev_q[k]  <= s_d[k];
        dout_q[k]  <= dout_d[k];
        cnt_q[k]   <= cnt_d[k];
        state_q[k] <= state_d[k];
      end
      trig_q   <= trig_d;
      // The first enabled cycle only loads prev; compares start on the next one.
      primed_q <= CHKEN;
      if (ERRCLR) begin
        errcnt_q <= '0;
      end else if (CHKEN && primed_q && mismatch && (errcnt_q != 16'hFFFF)) begin
        errcnt_q <= errcnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      DOUT[13*k +: 13] = dout_q[k];
    end
  end

  assign TRIG    = trig_q;
  assign TRIGANY = |trig_q;
  assign ERRCNT  = errcnt_q;

endmodule

// File: tb/tb_adc4proc.sv
// Self-checking bench for adc4proc: scoreboard queues for the data/trigger pipeline and
// a reference model for the discriminator and ramp checker.
module tb_adc4proc;
  localparam int unsigned HOLDOFF = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [47:0] din    = '0;
  logic [3:0]  inv    = '0;
  logic [47:0] ped    = '0;
  logic [47:0] thr    = '1;
  logic        chken  = 1'b0;
  logic        errclr = 1'b0;
  logic [51:0] dout;
  logic [3:0]  trig;
  logic        trigany;
  logic [15:0] errcnt;

  adc4proc #(.HOLDOFF(HOLDOFF)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .DIN    (din),
    .INV    (inv),
    .PED    (ped),
    .THR    (thr),
    .CHKEN  (chken),
    .ERRCLR (errclr),
    .DOUT   (dout),
    .TRIG   (trig),
    .TRIGANY(trigany),
    .ERRCNT (errcnt)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;
  int npulse;

  logic [47:0] sq[$];  // stage-1 values in flight
  logic [51:0] dq[$];  // expected DOUT words awaiting discrimination

  // Discriminator model: trigger when above and either never triggered, or a below-threshold
  // sample has been seen at least HOLDOFF evaluations after the last trigger.
  int          tcnt[4];
  int          last[4];
  bit          have_last[4];
  bit          rearm[4];

  bit          m_primed;
  logic [11:0] m_prev[4];
  logic [15:0] m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc1(input logic [11:0] r);
    return {r[5:0], r[11:6]};
  endfunction

  function automatic logic [47:0] enc(input logic [11:0] r0, input logic [11:0] r1,
                                      input logic [11:0] r2, input logic [11:0] r3);
    return {enc1(r3), enc1(r2), enc1(r1), enc1(r0)};
  endfunction

  function automatic logic [47:0] model_s(input logic [47:0] d, input logic [3:0] iv);
    logic [47:0] o;
    logic [11:0] raw;
    for (int k = 0; k < 4; k++) begin
      raw = {d[12*k +: 6], d[12*k+6 +: 6]};
      o[12*k +: 12] = iv[k] ? (12'd4095 - raw) : raw;
    end
    return o;
  endfunction

  task automatic eval_trig(input logic [51:0] d, output logic [3:0] tr);
    for (int k = 0; k < 4; k++) begin
      int dv;
      int tv;
      bit ab;
      dv = int'($signed(d[13*k +: 13]));
      tv = int'(thr[12*k +: 12]);
      ab = dv > tv;
      tr[k] = ab && (!have_last[k] || rearm[k]);
      if (tr[k]) begin
        last[k] = tcnt[k];
        have_last[k] = 1'b1;
        rearm[k] = 1'b0;
      end else if (have_last[k] && (tcnt[k] >= last[k] + int'(HOLDOFF)) && !ab) begin
        rearm[k] = 1'b1;
      end
      tcnt[k]++;
    end
  endtask

  task automatic step(input bit rst);
    logic [47:0] s;
    logic [47:0] sp;
    logic [51:0] ed;
    logic [3:0]  et;
    bit          hd;
    bit          ht;
    bit          mm;
    hd = 1'b0;
    ht = 1'b0;
    ed = '0;
    et = '0;
    if (!rst) begin
      s = model_s(din, inv);
      sq.push_back(s);
      if (dq.size() > 0) begin
        eval_trig(dq.pop_front(), et);
        ht = 1'b1;
      end
      if (sq.size() > 1) begin
        sp = sq.pop_front();
        for (int k = 0; k < 4; k++) begin
          ed[13*k +: 13] = 13'(int'(sp[12*k +: 12]) - int'(ped[12*k +: 12]));
        end
        dq.push_back(ed);
        hd = 1'b1;
      end
      mm = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (int'(s[12*k +: 12]) != (int'(m_prev[k]) + 1) % 4096) mm = 1'b1;
      end
      if (errclr) m_err = '0;
      else if (chken && m_primed && mm && m_err != 16'hFFFF) m_err = m_err + 16'd1;
      m_primed = chken;
      for (int k = 0; k < 4; k++) m_prev[k] = s[12*k +: 12];
    end
    rst_n = !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      sq.delete();
      dq.delete();
      sq.push_back('0);
      dq.push_back('0);
      for (int k = 0; k < 4; k++) begin
        have_last[k] = 1'b0;
        rearm[k] = 1'b0;
      end
      m_primed = 1'b0;
      m_err = '0;
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_trig", 64'(trig), 64'd0);
      check("rst_trigany", 64'(trigany), 64'd0);
      check("rst_errcnt", 64'(errcnt), 64'd0);
    end else begin
      if (hd) check("dout", 64'(dout), 64'(ed));
      if (ht) begin
        check("trig", 64'(trig), 64'(et));
        check("trigany", 64'(trigany), 64'(|et));
        npulse += int'(trig[0]);
      end
      check("errcnt", 64'(errcnt), 64'(m_err));
    end
  endtask

  initial begin
    step(1'b1);
    step(1'b1);

    // Lane ordering: lane0=0x2A, lane1=0x15 gives channel 0 = 0xA95.
    din = {36'h0, 6'h15, 6'h2A};
    step(1'b0);
    din = '0;
    repeat (3) step(1'b0);

    // Inversion with pedestal, then negative result.
    din = enc(12'h000, 12'h000, 12'h000, 12'h000);
    inv = 4'b0001;
    ped = {36'h0, 12'h800};
    step(1'b0);
    din = enc(12'h100, 12'h000, 12'h000, 12'h000);
    inv = 4'b0000;
    ped = {36'h0, 12'h200};
    step(1'b0);
    repeat (3) step(1'b0);

    repeat (30) begin
      din = {$urandom(), $urandom()};
      inv = 4'($urandom());
      ped = {$urandom(), $urandom()};
      step(1'b0);
    end
    din = '0;
    inv = '0;
    ped = '0;
    repeat (3) step(1'b0);

    // Hold-off: long step, then a second step two cycles after the drop.
    thr = {12'hFFF, 12'hFFF, 12'hFFF, 12'd100};
    npulse = 0;
    din = enc(12'd200, 12'd0, 12'd0, 12'd0);
    repeat (20) step(1'b0);
    din = '0;
    repeat (2) step(1'b0);
    din = enc(12'd200, 12'd0, 12'd0, 12'd0);
    repeat (5) step(1'b0);
    din = '0;
    repeat (12) step(1'b0);
    check("holdoff_pulses", 64'(npulse), 64'd2);

    // Short pulses inside the hold-off window: every second one triggers.
    npulse = 0;
    repeat (4) begin
      din = enc(12'd200, 12'd0, 12'd0, 12'd0);
      repeat (3) step(1'b0);
      din = '0;
      repeat (5) step(1'b0);
    end
    repeat (10) step(1'b0);
    check("rearm_pulses", 64'(npulse), 64'd2);

    // Reset mid-HOLD re-arms immediately.
    npulse = 0;
    din = enc(12'd200, 12'd0, 12'd0, 12'd0);
    repeat (4) step(1'b0);
    step(1'b1);
    repeat (4) step(1'b0);
    din = '0;
    repeat (4) step(1'b0);
    check("reset_hold_pulses", 64'(npulse), 64'd2);
    thr = '1;

    // Ramp with wrap, one bad value on channel 2 and its recovery count.
    chken = 1'b1;
    for (int v = 4094; v < 4099; v++) begin
      din = enc(12'(v), 12'(v), 12'(v), 12'(v));
      step(1'b0);
    end
    check("ramp_clean", 64'(errcnt), 64'd0);
    din = enc(12'd3, 12'd3, 12'd100, 12'd3);
    step(1'b0);
    check("ramp_bad", 64'(errcnt), 64'd1);
    for (int v = 4; v < 7; v++) begin
      din = enc(12'(v), 12'(v), 12'(v), 12'(v));
      step(1'b0);
    end
    check("ramp_recover", 64'(errcnt), 64'd2);

    // Saturation via a frozen pattern, then clear coinciding with an error.
    din = '0;
    repeat (65540) step(1'b0);
    check("sat", 64'(errcnt), 64'hFFFF);
    errclr = 1'b1;
    step(1'b0);
    check("clr_with_err", 64'(errcnt), 64'd0);
    errclr = 1'b0;
    chken = 1'b0;
    repeat (3) step(1'b0);
    chken = 1'b1;
    repeat (2) step(1'b0);
    check("restart", 64'(errcnt), 64'd1);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
